// File: rtl/pwm_seq_pkg.sv
// rtl/pwm_seq_pkg.sv - shared types for the PWM duty sequencer
package pwm_seq_pkg;

  // Encodings are visible on the phase output and must stay fixed.
  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_RISE    = 3'd1,
    PH_HOLD_HI = 3'd2,
    PH_FALL    = 3'd3,
    PH_HOLD_LO = 3'd4,
    PH_DRAIN   = 3'd5
  } phase_t;

endpackage

// File: rtl/step_divider.sv
// rtl/step_divider.sv - clock divider producing a one-cycle step strobe
module step_divider #(
  parameter int STEP_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  output logic step
);

  localparam int DW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == DW'(STEP_DIV - 1));

  // Free-running divider; step is registered so it rises the cycle after the wrap value.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      step    <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      step    <= wrap;
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - breathing duty profile generator feeding the pwm block
module pwm_duty_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int N                 = 8,
  parameter int STEP_DIV          = 16,
  parameter int PERIODS_PER_LEVEL = 4,
  parameter int HOLD_LEVELS       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [N-1:0] min_duty,
  input  logic [N-1:0] max_duty,
  output logic         step,
  output logic [N-1:0] duty,
  output logic         ena,
  output logic         period_done,
  output logic [2:0]   phase
);

  localparam int LW = (PERIODS_PER_LEVEL > 1) ? $clog2(PERIODS_PER_LEVEL) : 1;
  localparam int HW = $clog2(HOLD_LEVELS + 1);

  logic [N-1:0]  pcnt;
  logic [LW-1:0] lcnt;
  logic          lcnt_last;
  logic          level_tick;
  logic          hold_last;
  logic [N-1:0]  start_lo;

  phase_t        state, state_nx;
  logic [N-1:0]  duty_nx;
  logic          ena_nx;
  logic [N-1:0]  hi, hi_nx;
  logic [N-1:0]  lo, lo_nx;
  logic [HW-1:0] hcnt, hcnt_nx;

  step_divider #(.STEP_DIV(STEP_DIV)) u_step_divider (
    .clk  (clk),
    .rst  (rst),
    .step (step)
  );

  // Pre-increment pcnt at its top value means the downstream counter wraps on this edge.
  assign period_done = step && (pcnt == '1);
  assign lcnt_last   = (lcnt == LW'(PERIODS_PER_LEVEL - 1));
  assign level_tick  = period_done && lcnt_last;
  // The tick that lands on the end value counts as the first level of the hold.
  assign hold_last   = (int'(hcnt) + 2 >= HOLD_LEVELS);
  // An inverted floor/ceiling pair collapses to a flat profile at max_duty.
  assign start_lo    = (min_duty < max_duty) ? min_duty : max_duty;
  assign phase       = state;

  // Shadow of the downstream PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (step) begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Periods within the current level; parked at zero while idle so a restart gets a full level.
  always_ff @(posedge clk) begin
    if (rst || state == PH_IDLE) begin
      lcnt <= '0;
    end else if (period_done) begin
      lcnt <= lcnt_last ? '0 : lcnt + 1'b1;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PH_IDLE;
      duty  <= '0;
      ena   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_nx;
      duty  <= duty_nx;
      ena   <= ena_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
      hcnt  <= hcnt_nx;
    end
  end

  // Next-state logic; duty only moves on period boundaries, run-low only redirects phase.
  always_comb begin
    state_nx = state;
    duty_nx  = duty;
    ena_nx   = ena;
    hi_nx    = hi;
    lo_nx    = lo;
    hcnt_nx  = hcnt;
    case (state)
      PH_IDLE: begin
        if (period_done && run) begin
          state_nx = PH_RISE;
          hi_nx    = max_duty;
          lo_nx    = start_lo;
          duty_nx  = start_lo;
          ena_nx   = 1'b1;
        end
      end
      PH_RISE: begin
        if (!run) begin
          state_nx = PH_DRAIN;
        end else if (level_tick) begin
          if (duty == hi) begin
            state_nx = PH_HOLD_HI;
            hcnt_nx  = '0;
          end else begin
            duty_nx = duty + 1'b1;
          end
        end
      end
      PH_HOLD_HI: begin
        if (!run) begin
          state_nx = PH_DRAIN;
        end else if (level_tick) begin
          if (hold_last) begin
            state_nx = PH_FALL;
          end else begin
            hcnt_nx = hcnt + 1'b1;
          end
        end
      end
      PH_FALL: begin
        if (!run) begin
          state_nx = PH_DRAIN;
        end else if (level_tick) begin
          if (duty == lo) begin
            state_nx = PH_HOLD_LO;
            hcnt_nx  = '0;
          end else begin
            duty_nx = duty - 1'b1;
          end
        end
      end
      PH_HOLD_LO: begin
        if (!run) begin
          state_nx = PH_DRAIN;
        end else if (level_tick) begin
          if (hold_last) begin
            state_nx = PH_RISE;
            hi_nx    = max_duty;
            lo_nx    = start_lo;
            duty_nx  = start_lo;
          end else begin
            hcnt_nx = hcnt + 1'b1;
          end
        end
      end
      PH_DRAIN: begin
        if (level_tick) begin
          if (duty == '0) begin
            state_nx = PH_IDLE;
            ena_nx   = 1'b0;
          end else begin
            duty_nx = duty - 1'b1;
          end
        end
      end
      default: begin
        state_nx = PH_IDLE;
        duty_nx  = '0;
        ena_nx   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb/tb_pwm_duty_sequencer.sv - directed self-checking bench for pwm_duty_sequencer
module tb_pwm_duty_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] min_duty;
  logic [3:0] max_duty;
  logic       step;
  logic [3:0] duty;
  logic       ena;
  logic       period_done;
  logic [2:0] phase;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] pwm_cnt;
  logic       pwm_out;
  logic       mon_en = 1'b0;

  // Expected duty and phase for periods 1..31 after run first rises.
  int exp_duty [31] = '{2,3,4,5,5,5,4,3,2,2, 2,3,4,5,5,5,4,3,2,2,
                        3,3,3,3,3,3,3,3,2,3, 4};
  int exp_phase[31] = '{1,1,1,1,2,3,3,3,3,4, 1,1,1,1,2,3,3,3,3,4,
                        1,2,3,4,1,2,3,4,1,1, 1};

  always #5 clk = ~clk;

  pwm_duty_sequencer #(
    .N                 (4),
    .STEP_DIV          (2),
    .PERIODS_PER_LEVEL (1),
    .HOLD_LEVELS       (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .min_duty    (min_duty),
    .max_duty    (max_duty),
    .step        (step),
    .duty        (duty),
    .ena         (ena),
    .period_done (period_done),
    .phase       (phase)
  );

  // Reference downstream pwm counter.
  always @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else if (step) pwm_cnt <= pwm_cnt + 1'b1;
  end
  assign pwm_out = ena && (pwm_cnt < duty);

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next period boundary and sample the new period's values.
  task automatic next_period();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_done && n < 40);
    if (!period_done) check_eq("period_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Measures pwm high time per period and flags duty/ena moving off a boundary.
  task automatic monitor_loop();
    int   hi_acc    = 0;
    logic armed     = 1'b0;
    logic [3:0] prev_duty = '0;
    logic prev_ena  = 1'b0;
    logic prev_pd   = 1'b0;
    forever begin
      @(negedge clk);
      hi_acc += pwm_out ? 1 : 0;
      if (mon_en && (duty != prev_duty || ena != prev_ena))
        check_eq("change_on_boundary", int'(prev_pd), 1);
      if (period_done) begin
        if (mon_en && armed) check_eq("pwm_high_time", hi_acc, 2 * int'(duty));
        armed  = mon_en;
        hi_acc = 0;
      end
      prev_duty = duty;
      prev_ena  = ena;
      prev_pd   = period_done;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pd_cnt;
    rst      = 1'b1;
    run      = 1'b0;
    min_duty = '0;
    max_duty = '0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(negedge clk);
    check_eq("rst_duty", duty, 0);
    check_eq("rst_ena", ena, 0);
    check_eq("rst_phase", phase, 0);
    check_eq("rst_step", step, 0);
    check_eq("rst_period_done", period_done, 0);

    // Idle timing: step every 2 clocks, period_done every 32.
    rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      check_eq($sformatf("idle_step_k%0d", k), step, (k % 2 == 0) ? 1 : 0);
      check_eq($sformatf("idle_pd_k%0d", k), period_done, (k % 32 == 0) ? 1 : 0);
    end
    check_eq("idle_duty", duty, 0);
    check_eq("idle_ena", ena, 0);
    check_eq("idle_phase", phase, 0);

    // Breathing profile, flat profile from inverted limits, then a new range.
    run      = 1'b1;
    min_duty = 4'd2;
    max_duty = 4'd5;
    mon_en   = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 31; p++) begin
      if (p > 0) next_period();
      check_eq($sformatf("p%0d_duty", p + 1), duty, exp_duty[p]);
      check_eq($sformatf("p%0d_phase", p + 1), phase, exp_phase[p]);
      check_eq($sformatf("p%0d_ena", p + 1), ena, 1);
      if (p == 11) begin
        min_duty = 4'd9;
        max_duty = 4'd3;
      end
      if (p == 24) begin
        min_duty = 4'd2;
        max_duty = 4'd6;
      end
    end

    // Drop run mid-RISE at duty 4: phase moves at once, duty only at boundaries.
    run = 1'b0;
    @(negedge clk);
    check_eq("drain_enter_phase", phase, 5);
    check_eq("drain_enter_duty", duty, 4);
    for (int i = 0; i < 4; i++) begin
      next_period();
      check_eq($sformatf("drain_duty_%0d", i), duty, 3 - i);
      check_eq($sformatf("drain_phase_%0d", i), phase, 5);
      check_eq($sformatf("drain_ena_%0d", i), ena, 1);
    end
    next_period();
    check_eq("drain_done_phase", phase, 0);
    check_eq("drain_done_ena", ena, 0);
    check_eq("drain_done_duty", duty, 0);

    // Restart, reach HOLD_HI, then reset mid-period.
    run      = 1'b1;
    min_duty = 4'd1;
    max_duty = 4'd2;
    next_period();
    check_eq("restart_phase", phase, 1);
    check_eq("restart_duty", duty, 1);
    next_period();
    check_eq("restart_rise_duty", duty, 2);
    next_period();
    check_eq("restart_hold_phase", phase, 2);
    check_eq("restart_hold_duty", duty, 2);
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    check_eq("midrst_duty", duty, 0);
    check_eq("midrst_ena", ena, 0);
    check_eq("midrst_phase", phase, 0);
    check_eq("midrst_step", step, 0);
    check_eq("midrst_period_done", period_done, 0);
    rst    = 1'b0;
    pd_cnt = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 1) check_eq("post_rst_step_k1", step, 0);
      if (k == 2) check_eq("post_rst_step_k2", step, 1);
      if (period_done) pd_cnt++;
    end
    check_eq("post_rst_pd_k32", period_done, 1);
    check_eq("post_rst_pd_count", pd_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
